uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares a single `uart_tx` transmitter between up to eight byte-producing requesters with round-robin arbitration. The block sits between the requesters and the transmitter's `en`/`data_in`/`rdy` port, sequences one byte per grant and waits for the transmitter to finish before re-arbitrating. It replaces the direct `en = rdy & valid` glue wherever more than one source needs the serial line.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `IDW`, derived: `$clog2(NUM_REQ)`, width of `grant_id`.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: requester i has a byte pending.
- `req_data`  in  8*NUM_REQ: byte of requester i at bits [8i+7:8i].
- `req_lock`  in  NUM_REQ: requester i asks to keep the line for its next byte. Used only with `UART_ARB_LOCK_EN`.
- `req_ready`  out  NUM_REQ: one-cycle pulse; the byte of requester i was accepted.
- `tx_rdy`  in  1: `rdy` from `uart_tx`.
- `tx_en`  out  1: `en` to `uart_tx`, one-cycle pulse.
- `tx_data`  out  8: `data_in` to `uart_tx`, registered.
- `grant_id`  out  IDW: index of the last granted requester.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Requester handshake:
  - Requester i holds `req_valid[i]` and its byte stable until it sees `req_ready[i]`.
  - It may drop `req_valid[i]` or present a new byte in the cycle after the pulse.
- Requesters never see `tx_rdy` directly.
- State machine (all outputs registered):
  - IDLE: if `tx_rdy`=1 and any `req_valid`=1, pick winner g, go LAUNCH.
    - On the transition: latch `req_data[g]` into `tx_data`, set `grant_id`=g, and arm `req_ready[g]` and `tx_en` for the next cycle.
  - LAUNCH: `tx_en`=1 and `req_ready[g]`=1 for this single cycle. Go WAIT_BUSY.
  - WAIT_BUSY: stay until `tx_rdy`=0, then go WAIT_DONE.
  - WAIT_DONE: stay until `tx_rdy`=1, then go IDLE and update the round-robin pointer `last`=g.
- Round-robin:
  - Search starts at `last`+1 modulo NUM_REQ and takes the first asserted `req_valid`.
  - The winner becomes lowest priority next time.
  - A lone requester is granted back-to-back.
- `req_valid` changes outside IDLE are ignored. A request dropped before a grant is simply not served.
- `tx_data` holds its value until the next grant.
- Reset values:
  - State IDLE, `tx_en`=0, `req_ready`=0, `tx_data`=8'h00, `grant_id`=0, `busy`=0.
  - `last`=NUM_REQ-1, so requester 0 wins the first contention.
- Reset mid-operation: the FSM returns to IDLE next cycle and the byte in flight is dropped. `uart_tx` shares `rst` and aborts too.

## Timing
- Request at cycle N in IDLE with `tx_rdy`=1: `req_ready[g]` and `tx_en` are both high at N+1.
- `tx_en` is never asserted when `tx_rdy` was 0 in the preceding IDLE cycle.
- `uart_tx` drops `rdy` no later than 1 cycle after `en`. The FSM tolerates any delay by waiting in WAIT_BUSY.
- Re-arbitration happens no earlier than one cycle after `tx_rdy` returns high.
  - Byte-to-byte gap at the line is therefore frame time plus 3 clk.
  - At 32 MHz / 9600 baud the frame is 33340 clk.
- Simultaneous requests in the same IDLE cycle are resolved purely by round-robin order; there is no tie-break by index beyond that.
- At most one bit of `req_ready` is ever high. It is never high at the same time as `busy`=0.

## Configuration
- Macro: `UART_ARB_LOCK_EN`.
- Defined:
  - If `req_lock[g]`=1 when WAIT_DONE exits, the next IDLE arbitration considers only requester g, and `last` is not advanced.
  - The lock persists while `req_lock[g]`=1, which gives atomic multi-byte messages.
  - If g drops `req_valid` while locked, the arbiter waits in IDLE for it.
  - Deasserting `req_lock[g]` releases the lock at the next IDLE cycle.
- Undefined: `req_lock` is ignored (port kept, unused) and arbitration is pure round-robin.

## Test plan
- Single requester:
  - Stimulus: after reset, `req_valid[2]`=1, data 8'hA5, `tx_rdy` modelled by `uart_tx`.
  - Required: `req_ready[2]`=1 and `tx_en`=1 one cycle after the request, `tx_data`=8'hA5, `grant_id`=2, `busy` high until `rdy` returns.
- Contention:
  - Stimulus: all four requesters hold bytes 8'h10, 8'h11, 8'h12, 8'h13 continuously.
  - Required: transmit order 0,1,2,3,0,... with exactly one byte per grant.
- Transmitter not ready:
  - Stimulus: `tx_rdy` forced 0 for 100 cycles while `req_valid[1]`=1.
  - Required: no `tx_en`, no `req_ready`. Grant occurs 1 cycle after `tx_rdy` rises.
- Slow `rdy` drop:
  - Stimulus: `tx_rdy` held high 5 cycles after `tx_en`.
  - Required: FSM stays in WAIT_BUSY, no second `tx_en`, completes normally.
- Reset mid-frame:
  - Stimulus: `rst` asserted during WAIT_DONE.
  - Required: all outputs at reset values the next cycle; requester 0 wins the subsequent contention.
- With `UART_ARB_LOCK_EN`:
  - Stimulus: requester 3 sends 3 bytes with `req_lock[3]`=1 while requesters 0 and 1 are pending.
  - Required: bytes from requester 3 go out consecutively; requester 0 is granted after `req_lock[3]` falls.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of uart_tx_arbiter.
// slave: arbiter view, master: requesters plus uart_tx view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    localparam int IDW = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_lock;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_rdy;
    logic                 tx_en;
    logic [7:0]           tx_data;
    logic [IDW-1:0]       grant_id;
    logic                 busy;

    modport slave (
        input  req_valid, req_data, req_lock, tx_rdy,
        output req_ready, tx_en, tx_data, grant_id, busy
    );

    modport master (
        output req_valid, req_data, req_lock, tx_rdy,
        input  req_ready, tx_en, tx_data, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte requesters.
// Ports: clk, rst (sync, active high), bus (uart_tx_arbiter_if.slave):
//   req_valid/req_data/req_lock/req_ready toward the requesters,
//   tx_rdy/tx_en/tx_data toward uart_tx, grant_id and busy status.
// Macro UART_ARB_LOCK_EN: req_lock keeps the line for multi-byte messages.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE
    } state_t;

    state_t               state;
    logic [IDW-1:0]       last;
    logic [NUM_REQ-1:0]   cand;
    logic                 pick_found;
    logic [IDW-1:0]       pick;
    logic [IDW-1:0]       idx;
    logic [7:0]           pick_data;

    logic                 tx_en_q;
    logic [NUM_REQ-1:0]   ready_q;
    logic [7:0]           data_q;
    logic [IDW-1:0]       gid_q;
    logic                 busy_q;

`ifdef UART_ARB_LOCK_EN
    logic locked;
    logic lock_hold;

    // An active lock narrows arbitration to the holder alone.
    always_comb begin
        lock_hold = locked & bus.req_lock[gid_q];
        cand = bus.req_valid;
        if (lock_hold)
            cand = bus.req_valid & (NUM_REQ'(1) << gid_q);
    end
`else
    logic unused_lock;
    assign unused_lock = ^bus.req_lock;
    assign cand = bus.req_valid;
`endif

    // Search starts just after the last winner.
    always_comb begin
        pick_found = 1'b0;
        pick = '0;
        idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(last) + k) % NUM_REQ);
            if (!pick_found && cand[idx]) begin
                pick_found = 1'b1;
                pick = idx;
            end
        end
        pick_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick == IDW'(k))
                pick_data = bus.req_data[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= IDW'(NUM_REQ - 1);
            tx_en_q <= 1'b0;
            ready_q <= '0;
            data_q  <= 8'h00;
            gid_q   <= '0;
            busy_q  <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            locked  <= 1'b0;
`endif
        end else begin
            tx_en_q <= 1'b0;
            ready_q <= '0;
            case (state)
                IDLE: begin
`ifdef UART_ARB_LOCK_EN
                    if (!lock_hold)
                        locked <= 1'b0;
`endif
                    if (bus.tx_rdy && pick_found) begin
                        state   <= LAUNCH;
                        data_q  <= pick_data;
                        gid_q   <= pick;
                        ready_q <= NUM_REQ'(1) << pick;
                        tx_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                LAUNCH: state <= WAIT_BUSY;
                WAIT_BUSY: begin
                    if (!bus.tx_rdy)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.tx_rdy) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
`ifdef UART_ARB_LOCK_EN
                        // A locked holder keeps its place in the rotation.
                        locked <= bus.req_lock[gid_q];
                        if (!bus.req_lock[gid_q])
                            last <= gid_q;
`else
                        last <= gid_q;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_en     = tx_en_q;
    assign bus.req_ready = ready_q;
    assign bus.tx_data   = data_q;
    assign bus.grant_id  = gid_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a small uart_tx model.
// Vector table for single grants, scoreboard for round-robin sequences.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int FRAME = 8;

    typedef struct {
        logic [N-1:0]   mask;
        logic [8*N-1:0] data;
        int             drop;
        logic [1:0]     id;
        logic [7:0]     dat;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   total = 0;
    int   bad = 0;
    logic force_low = 1'b0;
    int   drop_delay = 0;
    int   m_cnt = 0;
    logic inv_bad = 1'b0;

    vec_t vt[7];
    exp_t sbq[$];
    exp_t e;
    int   lat;
    int   extra;
    bit   done;
    bit   flag;

    // uart_tx model: rdy stays high drop_delay cycles after en,
    // then low for FRAME cycles.
    assign bus.tx_rdy = !force_low && (m_cnt == 0 || m_cnt > FRAME);

    always @(posedge clk) begin
        if (rst)
            m_cnt <= 0;
        else if (bus.tx_en)
            m_cnt <= drop_delay + FRAME;
        else if (m_cnt != 0)
            m_cnt <= m_cnt - 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(bus.req_ready) > 1)
                inv_bad <= 1'b1;
            if (bus.req_ready != '0 && !bus.busy)
                inv_bad <= 1'b1;
            if (bus.tx_en && !bus.busy)
                inv_bad <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_en(input int bound, output int l);
        l = 0;
        while (l < bound) begin
            @(negedge clk);
            l++;
            if (bus.tx_en)
                return;
        end
        l = -1;
    endtask

    task automatic wait_idle(input int bound, output int ens,
                             output bit ok);
        ens = 0;
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (bus.tx_en)
                ens++;
            if (!bus.busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_lock = '0;
        force_low = 1'b0;
        drop_delay = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vt[0] = '{4'b0100, 32'h13A51110, 0, 2'd2, 8'hA5};
        vt[1] = '{4'b0001, 32'h13121110, 0, 2'd0, 8'h10};
        vt[2] = '{4'b1010, 32'h13121110, 0, 2'd1, 8'h11};
        vt[3] = '{4'b1010, 32'h13121110, 0, 2'd3, 8'h13};
        vt[4] = '{4'b0011, 32'h13121110, 0, 2'd0, 8'h10};
        vt[5] = '{4'b1000, 32'h13121110, 5, 2'd3, 8'h13};
        vt[6] = '{4'b0110, 32'h13121110, 0, 2'd1, 8'h11};

        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.req_lock = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_en", bus.tx_en, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_grant", bus.grant_id, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drop_delay = vt[i].drop;
            bus.req_data = vt[i].data;
            bus.req_valid = vt[i].mask;
            wait_en(20, lat);
            chk($sformatf("v%0d_lat", i), lat, 1);
            chk($sformatf("v%0d_id", i), bus.grant_id, vt[i].id);
            chk($sformatf("v%0d_data", i), bus.tx_data, vt[i].dat);
            chk($sformatf("v%0d_ready", i), bus.req_ready,
                N'(1) << vt[i].id);
            chk($sformatf("v%0d_busy", i), bus.busy, 1);
            bus.req_valid = '0;
            wait_idle(60, extra, done);
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_extra_en", i), extra, 0);
            chk($sformatf("v%0d_hold", i), bus.tx_data, vt[i].dat);
        end

        // All four requesters contend continuously.
        reset_dut();
        bus.req_data = 32'h13121110;
        for (int k = 0; k < 8; k++)
            sbq.push_back('{id: 2'(k % 4), dat: 8'(8'h10 + k % 4)});
        bus.req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            wait_en(60, lat);
            chk("rr_seen", lat > 0, 1);
            e = sbq.pop_front();
            chk("rr_id", bus.grant_id, e.id);
            chk("rr_data", bus.tx_data, e.dat);
            chk("rr_ready", bus.req_ready, N'(1) << e.id);
            if (k == 7)
                bus.req_valid = '0;
            @(negedge clk);
            chk("rr_pulse", bus.tx_en, 0);
        end
        wait_idle(60, extra, done);
        chk("rr_done", done, 1);

        // Transmitter not ready for 100 cycles.
        @(negedge clk);
        force_low = 1'b1;
        bus.req_valid = 4'b0010;
        flag = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.tx_en || bus.req_ready != '0 || bus.busy)
                flag = 1'b1;
        end
        chk("nr_quiet", flag, 0);
        force_low = 1'b0;
        wait_en(10, lat);
        chk("nr_lat", lat, 1);
        chk("nr_id", bus.grant_id, 1);
        chk("nr_data", bus.tx_data, 8'h11);
        bus.req_valid = '0;
        wait_idle(60, extra, done);
        chk("nr_done", done, 1);

        // Reset while waiting for the frame to finish.
        @(negedge clk);
        bus.req_valid = 4'b0100;
        wait_en(20, lat);
        chk("mr_id", bus.grant_id, 2);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        chk("mr_in_wait_done", {bus.busy, bus.tx_rdy}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_tx_en", bus.tx_en, 0);
        chk("mr_ready", bus.req_ready, 0);
        chk("mr_tx_data", bus.tx_data, 0);
        chk("mr_grant", bus.grant_id, 0);
        chk("mr_busy", bus.busy, 0);
        rst = 1'b0;
        bus.req_valid = '1;
        wait_en(20, lat);
        chk("mr_lat", lat, 1);
        chk("mr_first_id", bus.grant_id, 0);
        chk("mr_first_data", bus.tx_data, 8'h10);
        bus.req_valid = '0;
        wait_idle(60, extra, done);
        chk("mr_done", done, 1);

`ifdef UART_ARB_LOCK_EN
        // Requester 3 sends three locked bytes while 0 and 1 wait.
        reset_dut();
        bus.req_data = 32'h31121110;
        bus.req_lock = 4'b1000;
        bus.req_valid = 4'b1000;
        sbq.push_back('{id: 2'd3, dat: 8'h31});
        sbq.push_back('{id: 2'd3, dat: 8'h32});
        sbq.push_back('{id: 2'd3, dat: 8'h33});
        sbq.push_back('{id: 2'd0, dat: 8'h10});
        for (int k = 0; k < 4; k++) begin
            wait_en(60, lat);
            chk("lk_seen", lat > 0, 1);
            e = sbq.pop_front();
            chk("lk_id", bus.grant_id, e.id);
            chk("lk_data", bus.tx_data, e.dat);
            case (k)
                0: begin
                    bus.req_valid = 4'b1011;
                    bus.req_data[31:24] = 8'h32;
                end
                1: bus.req_data[31:24] = 8'h33;
                2: begin
                    bus.req_lock = '0;
                    bus.req_valid = 4'b0011;
                end
                default: bus.req_valid = '0;
            endcase
        end
        wait_idle(60, extra, done);
        chk("lk_done", done, 1);
`endif

        @(negedge clk);
        chk("invariant", inv_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
